// File: rtl/sdram_bram_responder_if.sv
// FIFO-side SDRAM request/ack bus between an initiator (master) and the
// responder standing in for the SDRAM controller (slave).
interface sdram_bram_responder_if #(
  parameter int DATA_W = 16
);
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic [21:0]       sys_wraddr;
  logic [21:0]       sys_rdaddr;
  logic [8:0]        sdwr_byte;
  logic [8:0]        sdrd_byte;
  logic [DATA_W-1:0] sys_data_in;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [DATA_W-1:0] sys_data_out;
  logic              sdram_init_done;

  modport master (
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
           sdwr_byte, sdrd_byte, sys_data_in,
    input  sdram_wr_ack, sdram_rd_ack, sys_data_out, sdram_init_done
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
           sdwr_byte, sdrd_byte, sys_data_in,
    output sdram_wr_ack, sdram_rd_ack, sys_data_out, sdram_init_done
  );
endinterface

// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller, speaking the dcfifo req/ack burst protocol.
// Define SDRAM_RESP_STATS_EN to add completed-burst counters wr_burst_cnt / rd_burst_cnt.
module sdram_bram_responder #(
  parameter int MEM_AW      = 12,
  parameter int DATA_W      = 16,
  parameter int INIT_CYCLES = 200,
  parameter int RD_LAT      = 2,
  parameter int GAP         = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sdram_bram_responder_if.slave  bus
`ifdef SDRAM_RESP_STATS_EN
  ,
  output logic [15:0]            wr_burst_cnt,
  output logic [15:0]            rd_burst_cnt
`endif
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_BURST, S_WR_TAIL, S_RD_WAIT, S_RD_BURST, S_GAP
  } state_t;

  state_t            state;
  logic [31:0]       cnt;
  logic [8:0]        beats;
  logic [MEM_AW-1:0] ptr;
  logic              last_wr;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic              wr_beat_q;
  logic              init_done_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic grant_wr;
  logic grant_rd;
  logic rd_issue;
  logic unused_addr_hi;

  assign unused_addr_hi = ^{bus.sys_wraddr[21:MEM_AW], bus.sys_rdaddr[21:MEM_AW]};

  // Ties alternate against the previous grant; last_wr resets low so the first tie writes.
  assign grant_wr = bus.sdram_wr_req && (!bus.sdram_rd_req || !last_wr);
  assign grant_rd = bus.sdram_rd_req && !grant_wr;

  // One BRAM read in the last wait cycle, then one per ack cycle except the final one.
  assign rd_issue = ((state == S_RD_WAIT) && (cnt == 32'(RD_LAT - 1))) ||
                    ((state == S_RD_BURST) && (beats != 9'd1));

  assign bus.sdram_wr_ack    = wr_ack_q;
  assign bus.sdram_rd_ack    = rd_ack_q;
  assign bus.sys_data_out    = rd_data_q;
  assign bus.sdram_init_done = init_done_q;

  function automatic logic [8:0] burst_len(input logic [8:0] len);
    return (len == 9'd0) ? 9'd1 : len;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      beats       <= '0;
      ptr         <= '0;
      last_wr     <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      wr_beat_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      // Initiator FIFO has one cycle of read latency: data follows each ack by a cycle.
      wr_beat_q <= wr_ack_q;
      if (wr_beat_q || rd_issue) ptr <= ptr + 1'b1;

      case (state)
        S_INIT: begin
          if (cnt == 32'(INIT_CYCLES - 1)) begin
            state       <= S_IDLE;
            cnt         <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_IDLE: begin
          if (grant_wr) begin
            ptr      <= bus.sys_wraddr[MEM_AW-1:0];
            beats    <= burst_len(bus.sdwr_byte);
            last_wr  <= 1'b1;
            wr_ack_q <= 1'b1;
            state    <= S_WR_BURST;
          end else if (grant_rd) begin
            ptr     <= bus.sys_rdaddr[MEM_AW-1:0];
            beats   <= burst_len(bus.sdrd_byte);
            last_wr <= 1'b0;
            cnt     <= '0;
            state   <= S_RD_WAIT;
          end
        end

        S_WR_BURST: begin
          if (beats == 9'd1) begin
            wr_ack_q <= 1'b0;
            state    <= S_WR_TAIL;
          end else begin
            beats <= beats - 9'd1;
          end
        end

        S_WR_TAIL: begin
          cnt   <= '0;
          state <= (GAP == 0) ? S_IDLE : S_GAP;
        end

        S_RD_WAIT: begin
          if (cnt == 32'(RD_LAT - 1)) begin
            rd_ack_q <= 1'b1;
            state    <= S_RD_BURST;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_RD_BURST: begin
          if (beats == 9'd1) begin
            rd_ack_q <= 1'b0;
            cnt      <= '0;
            state    <= (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            beats <= beats - 9'd1;
          end
        end

        S_GAP: begin
          if (cnt == 32'(GAP - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

  // Reset blocks the write at its own edge so an aborted burst stops cleanly.
  always_ff @(posedge clk) begin
    if (!rst && wr_beat_q) mem[ptr] <= bus.sys_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst)           rd_data_q <= '0;
    else if (rd_issue) rd_data_q <= mem[ptr];
  end

`ifdef SDRAM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
    end else begin
      if (state == S_WR_TAIL) wr_burst_cnt <= wr_burst_cnt + 16'd1;
      if ((state == S_RD_BURST) && (beats == 9'd1)) rd_burst_cnt <= rd_burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Scoreboarded random/directed bench for sdram_bram_responder against an array model
// of the memory and the req/ack burst rules.
module tb_sdram_bram_responder;
  localparam int MEM_AW = 12, DATA_W = 16, INIT_CYCLES = 200, RD_LAT = 2, GAP = 2;
  localparam int DEPTH = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_bram_responder_if #(.DATA_W(DATA_W)) bus ();
`ifdef SDRAM_RESP_STATS_EN
  logic [15:0] wr_burst_cnt, rd_burst_cnt;
`endif

  sdram_bram_responder #(
    .MEM_AW(MEM_AW), .DATA_W(DATA_W), .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SDRAM_RESP_STATS_EN
    ,
    .wr_burst_cnt(wr_burst_cnt),
    .rd_burst_cnt(rd_burst_cnt)
`endif
  );

  typedef struct { logic [15:0] d; bit care; } rd_exp_t;

  int chk = 0, err = 0;
  rd_exp_t     exp_rd_q[$];
  int          exp_wr_len_q[$];
  int          exp_rd_len_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  int          exp_wr_cnt = 0, exp_rd_cnt = 0;

  int      cyc = 0, wr_run = 0, rd_run = 0, last_end = -100, rises = 0;
  byte     order_q[$];
  int      gap_q[$];
  rd_exp_t mon_e;
  bit      drv_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard read data and burst lengths, log grant order and idle gaps.
  always @(negedge clk) begin
    cyc++;
    if (bus.sdram_rd_ack) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected_ack", 1, 0);
      else begin
        mon_e = exp_rd_q.pop_front();
        if (mon_e.care) check("rd_data", bus.sys_data_out, mon_e.d);
      end
    end
    if ((bus.sdram_wr_ack && wr_run == 0) || (bus.sdram_rd_ack && rd_run == 0)) begin
      rises++;
      order_q.push_back(bus.sdram_wr_ack ? 8'h57 : 8'h52);
      gap_q.push_back(cyc - last_end - 1);
    end
    if (bus.sdram_wr_ack) wr_run++;
    else if (wr_run > 0) begin
      if (exp_wr_len_q.size() == 0) check("wr_unexpected_burst", 1, 0);
      else check("wr_ack_len", wr_run, exp_wr_len_q.pop_front());
      wr_run = 0;
    end
    if (bus.sdram_rd_ack) rd_run++;
    else if (rd_run > 0) begin
      if (exp_rd_len_q.size() == 0) check("rd_unexpected_burst", 1, 0);
      else check("rd_ack_len", rd_run, exp_rd_len_q.pop_front());
      rd_run = 0;
    end
    if (bus.sdram_wr_ack || bus.sdram_rd_ack) last_end = cyc;
  end

  // Initiator FIFO: a word pops one cycle after each ack cycle.
  initial forever begin
    @(negedge clk) drv_a = bus.sdram_wr_ack;
    @(posedge clk);
    #1;
    if (drv_a && wr_data_q.size() > 0) bus.sys_data_in = wr_data_q.pop_front();
  end

  task automatic wait_rise(input bit is_wr, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(is_wr ? bus.sdram_wr_ack : bus.sdram_rd_ack) && n < 3000);
    if (n >= 3000) check(is_wr ? "wr_ack_timeout" : "rd_ack_timeout", 0, 1);
  endtask

  task automatic wait_fall(input bit is_wr);
    int n = 0;
    while ((is_wr ? bus.sdram_wr_ack : bus.sdram_rd_ack) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) check(is_wr ? "wr_ack_stuck" : "rd_ack_stuck", 1, 0);
  endtask

  function automatic int widx(input logic [21:0] addr, input int k);
    return (int'(addr[MEM_AW-1:0]) + k) % DEPTH;
  endfunction

  function automatic int nlen(input logic [8:0] len);
    return (len == 9'd0) ? 1 : int'(len);
  endfunction

  task automatic push_wr(input logic [21:0] addr, input logic [8:0] len,
                         input bit use_pat, input logic [15:0] pat);
    logic [15:0] d;
    for (int k = 0; k < nlen(len); k++) begin
      d = use_pat ? pat + 16'(k) : 16'($urandom);
      wr_data_q.push_back(d);
      model_mem[widx(addr, k)] = d;
      model_vld[widx(addr, k)] = 1'b1;
    end
    exp_wr_len_q.push_back(nlen(len));
    exp_wr_cnt++;
  endtask

  task automatic push_rd(input logic [21:0] addr, input logic [8:0] len);
    rd_exp_t e;
    for (int k = 0; k < nlen(len); k++) begin
      e.d = model_mem[widx(addr, k)];
      e.care = model_vld[widx(addr, k)];
      exp_rd_q.push_back(e);
    end
    exp_rd_len_q.push_back(nlen(len));
    exp_rd_cnt++;
  endtask

  task automatic do_write(input logic [21:0] addr, input logic [8:0] len,
                          input bit use_pat, input logic [15:0] pat);
    int n;
    push_wr(addr, len, use_pat, pat);
    @(negedge clk);
    bus.sys_wraddr = addr; bus.sdwr_byte = len; bus.sdram_wr_req = 1'b1;
    wait_rise(1'b1, n);
    bus.sdram_wr_req = 1'b0;
    bus.sys_wraddr = 22'($urandom); bus.sdwr_byte = 9'($urandom);
    wait_fall(1'b1);
  endtask

  task automatic do_read(input logic [21:0] addr, input logic [8:0] len, output int lat);
    push_rd(addr, len);
    @(negedge clk);
    bus.sys_rdaddr = addr; bus.sdrd_byte = len; bus.sdram_rd_req = 1'b1;
    wait_rise(1'b0, lat);
    bus.sdram_rd_req = 1'b0;
    bus.sys_rdaddr = 22'($urandom); bus.sdrd_byte = 9'($urandom);
    wait_fall(1'b0);
  endtask

  // Counts init_done-low cycles after reset; optionally pokes wr_req during INIT.
  task automatic measure_init(input int start, input bit poke, output int n_low, output int acks);
    n_low = start; acks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.sdram_init_done) break;
      n_low++;
      if (bus.sdram_wr_ack) acks++;
      if (poke && n_low == 5) begin
        bus.sys_wraddr = 22'h55; bus.sdwr_byte = 9'd1; bus.sdram_wr_req = 1'b1;
      end
      if (poke && n_low == 150) bus.sdram_wr_req = 1'b0;
    end
  endtask

  initial begin
    int lat, n_low, acks, n;
    logic [21:0] bases[$];
    logic [21:0] a;
    logic [8:0]  l;
    string       exp_order;

    bus.sdram_wr_req = 1'b0; bus.sdram_rd_req = 1'b0;
    bus.sys_wraddr = '0; bus.sys_rdaddr = '0;
    bus.sdwr_byte = '0; bus.sdrd_byte = '0; bus.sys_data_in = '0;
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;

    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_wr_ack", bus.sdram_wr_ack, 0);
    check("reset_rd_ack", bus.sdram_rd_ack, 0);
    check("reset_data_out", bus.sys_data_out, 0);
    check("reset_init_done", bus.sdram_init_done, 0);
    measure_init(1, 1'b1, n_low, acks);
    check("init_low_cycles", n_low, INIT_CYCLES);
    check("acks_during_init", acks, 0);
    repeat (10) @(negedge clk);

    do_write(22'h10, 9'd8, 1'b1, 16'hA000);
    repeat (8) @(negedge clk);
    do_read(22'h10, 9'd8, lat);
    check("rd_first_ack_latency", lat, RD_LAT + 1);

    do_write(22'h2A0FFE, 9'd4, 1'b1, 16'hB000);
    do_read(22'h000000, 9'd2, lat);
    do_read(22'h3F0FFE, 9'd4, lat);
    check("wrap_model_0x000", model_mem[0], 16'hB002);

    do_write(22'h200, 9'd0, 1'b1, 16'h5A5A);
    do_read(22'h200, 9'd0, lat);

    bases.push_back(22'h10);
    for (int it = 0; it < 16; it++) begin
      l = 9'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 0) begin
        a = 22'($urandom);
        bases.push_back(a);
        do_write(a, l, 1'b0, 16'h0);
      end else begin
        a = ($urandom_range(0, 3) != 0) ? bases[$urandom_range(0, bases.size() - 1)]
                                         : 22'($urandom);
        do_read(a, l, lat);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Last grant a read, so the first tie goes to write.
    do_read(22'h10, 9'd4, lat);
    order_q.delete(); gap_q.delete();
    n = rises;
    push_wr(22'h800, 9'd4, 1'b0, 16'h0); push_rd(22'h10, 9'd4);
    push_wr(22'h800, 9'd4, 1'b0, 16'h0); push_rd(22'h10, 9'd4);
    @(negedge clk);
    bus.sys_wraddr = 22'h800; bus.sdwr_byte = 9'd4;
    bus.sys_rdaddr = 22'h10;  bus.sdrd_byte = 9'd4;
    bus.sdram_wr_req = 1'b1; bus.sdram_rd_req = 1'b1;
    for (int i = 0; i < 3000 && rises < n + 4; i++) begin @(negedge clk); #1; end
    bus.sdram_wr_req = 1'b0; bus.sdram_rd_req = 1'b0;
    check("alt_grants_seen", rises - n, 4);
    repeat (30) @(negedge clk);
    exp_order = "WRWR";
    for (int i = 0; i < 4; i++) begin
      check("alt_order", (i < order_q.size()) ? order_q[i] : 8'h3F, exp_order[i]);
      if (i > 0) check("alt_gap_min", (i < gap_q.size() && gap_q[i] >= GAP + 1) ? 1 : 0, 1);
    end
`ifdef SDRAM_RESP_STATS_EN
    check("stats_wr", wr_burst_cnt, 16'(exp_wr_cnt));
    check("stats_rd", rd_burst_cnt, 16'(exp_rd_cnt));
`endif

    // Abort: reset sampled at the end of the 4th ack cycle of a 16-word write.
    do_write(22'h300, 9'd16, 1'b1, 16'hC000);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) wr_data_q.push_back(16'hD000 + 16'(k));
    model_mem[widx(22'h300, 0)] = 16'hD000;
    model_mem[widx(22'h300, 1)] = 16'hD001;
    exp_wr_len_q.push_back(4);
    @(negedge clk);
    bus.sys_wraddr = 22'h300; bus.sdwr_byte = 9'd16; bus.sdram_wr_req = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && n < 4; i++) begin
      @(negedge clk);
      if (bus.sdram_wr_ack) n++;
    end
    check("abort_acks_before_rst", n, 4);
    rst = 1'b1; bus.sdram_wr_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    exp_wr_cnt = 0; exp_rd_cnt = 0;
    @(negedge clk);
    wr_data_q.delete();
    check("abort_wr_ack_low", bus.sdram_wr_ack, 0);
    check("abort_init_done_low", bus.sdram_init_done, 0);
    check("abort_data_out_cleared", bus.sys_data_out, 0);
`ifdef SDRAM_RESP_STATS_EN
    check("stats_wr_reset", wr_burst_cnt, 0);
    check("stats_rd_reset", rd_burst_cnt, 0);
`endif
    measure_init(1, 1'b0, n_low, acks);
    check("reinit_low_cycles", n_low, INIT_CYCLES);
    do_read(22'h300, 9'd16, lat);
    repeat (6) @(negedge clk);
`ifdef SDRAM_RESP_STATS_EN
    check("stats_wr_after", wr_burst_cnt, 16'(exp_wr_cnt));
    check("stats_rd_after", rd_burst_cnt, 16'(exp_rd_cnt));
`endif
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("wr_len_queue_drained", exp_wr_len_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #500000;
    chk++; err++;
    $display("FAIL watchdog: simulation still running at %0t, completion required", $time);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
